reset_sequencer: RTL and testbench

Multi-channel reset generator replacing the single-output reset bridge in block designs. It merges the board reset, an external asynchronous reset request and a software reset pulse. It holds every downstream reset for a minimum time, then releases NUM_CH active-low reset outputs one after another in index order with a fixed gap. It sits between the clocking/board logic and the core, bus fabric and peripherals, all of which share one clock domain.

---
 rtl/reset_sequencer_pkg.sv | 29 ++
 rtl/reset_sync_cell.sv | 40 ++++
 rtl/reset_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer_pkg
//  Purpose  : Shared types and constants for the reset sequencer.
//             Holds the sequencer state encoding and the bit positions of
//             the optional reset-cause record.
//  Revision : 1.0  initial release
// ============================================================================
package reset_sequencer_pkg;

    // Sequencer states. The encoding is fixed so that debug taps and
    // status readback tools can decode it directly.
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    // Reset-cause record layout (one bit per source).
    localparam int CAUSE_W     = 3;
    localparam int CAUSE_BOARD = 0;
    localparam int CAUSE_EXT   = 1;
    localparam int CAUSE_SW    = 2;

    // Value of the cause record after a board reset.
    localparam logic [CAUSE_W-1:0] CAUSE_BOARD_ONLY = CAUSE_W'(1) << CAUSE_BOARD;

endpackage : reset_sequencer_pkg
`default_nettype wire

// File: rtl/reset_sync_cell.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sync_cell
//  Purpose  : Multi-flop synchronizer with an asynchronous clear.
//             i_rst_n low forces every stage to RESET_LEVEL immediately;
//             i_d is then shifted through STAGES flops on i_clk.
//             With i_d tied to the inactive level and RESET_LEVEL at the
//             active level this is an async-assert / sync-deassert reset
//             bridge; with i_d driven by a signal it is a level
//             synchronizer that is cleared by the board reset.
//  Ports    : i_clk    - destination clock
//             i_rst_n  - asynchronous active-low clear
//             i_d      - asynchronous input level
//             o_q      - synchronized level
//  Revision : 1.0  initial release
// ============================================================================
module reset_sync_cell #(
    parameter int STAGES      = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : reset_sync_cell
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Multi-channel reset generator. Merges the board reset, an
//             external asynchronous reset request and a software reset
//             pulse, holds all channel resets for HOLD_CYCLES clocks, then
//             releases the NUM_CH channels one at a time (bit 0 first)
//             with RELEASE_GAP clocks between releases.
//  Ports    : i_aclk       - clock
//             i_areset_n   - board reset, async assert, synchronized release
//             i_ext_reset  - external reset request, async, active high
//             i_sw_reset   - software reset pulse, i_aclk domain
//             o_areset_n   - per-channel active-low resets
//             o_busy       - sequence not yet complete
//             o_done       - all channels released
//             o_cause      - (RESET_SEQUENCER_CAUSE_EN only) one-hot record
//                            of the last reset source: bit0 board, bit1 ext,
//                            bit2 sw
//  Config   : define RESET_SEQUENCER_CAUSE_EN to add the o_cause output.
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int RELEASE_GAP = 4
) (
    input  logic              i_aclk,
    input  logic              i_areset_n,
    input  logic              i_ext_reset,
    input  logic              i_sw_reset,
    output logic [NUM_CH-1:0] o_areset_n,
    output logic              o_busy,
    output logic              o_done
`ifdef RESET_SEQUENCER_CAUSE_EN
    ,
    output logic [CAUSE_W-1:0] o_cause
`endif
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(RELEASE_GAP + 1);

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  c_gap_last  = GAP_W'(RELEASE_GAP - 1);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic w_rst_sync_n;
    logic w_ext_sync;

    // Board reset bridge: asserts the internal reset as soon as
    // i_areset_n falls, releases it SYNC_STAGES edges after it rises.
    reset_sync_cell #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (1'b0)
    ) u_areset_sync (
        .i_clk   (i_aclk),
        .i_rst_n (i_areset_n),
        .i_d     (1'b1),
        .o_q     (w_rst_sync_n)
    );

    // External request synchronizer. It is cleared by the board reset so
    // a stale request captured before power-up cannot outlive it.
    reset_sync_cell #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (1'b0)
    ) u_ext_sync (
        .i_clk   (i_aclk),
        .i_rst_n (i_areset_n),
        .i_d     (i_ext_reset),
        .o_q     (w_ext_sync)
    );

    // The board source is handled by the asynchronous reset of the
    // sequencer registers; only ext and sw are seen in the clocked path.
    logic w_src_any;
    assign w_src_any = w_ext_sync | i_sw_reset;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    seq_state_e        r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [GAP_W-1:0]  r_gap;
    logic [NUM_CH-1:0] r_mask;
    logic              r_busy;
    logic              r_done;

    // Release mask after one more channel is let go. Channels are released
    // strictly from bit 0 upward, so the mask is always a thermometer code.
    logic [NUM_CH-1:0] w_next_mask;

    always_comb begin
        w_next_mask    = r_mask << 1;
        w_next_mask[0] = 1'b1;
    end

    always_ff @(posedge i_aclk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state <= ASSERT;
            r_hold  <= '0;
            r_gap   <= '0;
            r_mask  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (w_src_any) begin
            // Any source drops every channel together and restarts the
            // hold interval, regardless of the current state.
            r_state <= ASSERT;
            r_hold  <= '0;
            r_gap   <= '0;
            r_mask  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                ASSERT: begin
                    if (r_hold == c_hold_last) begin
                        r_hold <= '0;
                        r_gap  <= '0;
                        r_mask <= w_next_mask;
                        // A single-channel build finishes on the first release.
                        if (w_next_mask[NUM_CH-1]) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end

                RELEASE: begin
                    if (r_gap == c_gap_last) begin
                        r_gap  <= '0;
                        r_mask <= w_next_mask;
                        if (w_next_mask[NUM_CH-1]) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                RUN: begin
                    r_mask <= '1;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end

                default: begin
                    r_state <= ASSERT;
                    r_hold  <= '0;
                    r_gap   <= '0;
                    r_mask  <= '0;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_areset_n = r_mask;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

`ifdef RESET_SEQUENCER_CAUSE_EN
    // ------------------------------------------------------------------
    // Reset cause record
    // ------------------------------------------------------------------
    logic [CAUSE_W-1:0] w_src_vec;
    logic [CAUSE_W-1:0] r_cause;

    always_comb begin
        w_src_vec              = '0;
        w_src_vec[CAUSE_EXT]   = w_ext_sync;
        w_src_vec[CAUSE_SW]    = i_sw_reset;
    end

    // Entering ASSERT from RELEASE/RUN replaces the record; sources that
    // arrive while already holding are accumulated so overlapping requests
    // are all visible.
    always_ff @(posedge i_aclk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_cause <= CAUSE_BOARD_ONLY;
        end else if (w_src_any) begin
            if (r_state == ASSERT) begin
                r_cause <= r_cause | w_src_vec;
            end else begin
                r_cause <= w_src_vec;
            end
        end
    end

    assign o_cause = r_cause;
`endif

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Self-checking bench for reset_sequencer. A timestamp model
//             ("edges since the last reset request was seen") predicts the
//             channel mask, busy, done and cause on every cycle; directed
//             scenarios add literal expectations on top.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HOLD_CYCLES = 16;
    localparam int RELEASE_GAP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset_n = 1'b0;
    logic ext      = 1'b0;
    logic sw       = 1'b0;

    logic [NUM_CH-1:0] dut_rst_n;
    logic              dut_busy;
    logic              dut_done;
`ifdef RESET_SEQUENCER_CAUSE_EN
    logic [2:0]        dut_cause;
`endif

    reset_sequencer #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .RELEASE_GAP (RELEASE_GAP)
    ) dut (
        .i_aclk      (clk),
        .i_areset_n  (areset_n),
        .i_ext_reset (ext),
        .i_sw_reset  (sw),
        .o_areset_n  (dut_rst_n),
        .o_busy      (dut_busy),
        .o_done      (dut_done)
`ifdef RESET_SEQUENCER_CAUSE_EN
        ,
        .o_cause     (dut_cause)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: count edges since the sequencer last saw a reset
    // request; channel k is released once that count reaches
    // HOLD_CYCLES + k*RELEASE_GAP.
    // ------------------------------------------------------------------
    int                 since   = 0;
    logic [2:0]         m_cause = 3'b001;
    logic [SYNC_STAGES:0] a_hist = '0;
    logic [SYNC_STAGES:0] x_hist = '0;

    function automatic logic [NUM_CH-1:0] exp_mask(input int s);
        logic [NUM_CH-1:0] m;
        for (int k = 0; k < NUM_CH; k++) m[k] = (s >= HOLD_CYCLES + k * RELEASE_GAP);
        return m;
    endfunction

    always @(posedge clk) begin : model
        logic       board;
        logic       extv;
        logic [2:0] src;
        a_hist = {a_hist[SYNC_STAGES-1:0], areset_n};
        x_hist = {x_hist[SYNC_STAGES-1:0], ext};
        // The board reset is still held at this edge if it was low at any
        // of the last SYNC_STAGES+1 samples.
        board = (a_hist != '1);
        // An external request reaches the sequencer SYNC_STAGES edges late.
        extv  = x_hist[SYNC_STAGES];
        src   = {sw, extv, 1'b0};
        if (board) begin
            since   = 0;
            m_cause = 3'b001;
        end else if (src != 3'b000) begin
            if (since < HOLD_CYCLES) m_cause = m_cause | src;
            else                     m_cause = src;
            since = 0;
        end else if (since < 100000) begin
            since++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [NUM_CH-1:0] em;
        logic              ed;
        logic [2:0]        ec;
        if (!areset_n) begin
            em = '0;
            ed = 1'b0;
            ec = 3'b001;
        end else begin
            em = exp_mask(since);
            ed = (since >= HOLD_CYCLES + (NUM_CH - 1) * RELEASE_GAP);
            ec = m_cause;
        end
        chk("cyc_mask", 32'(dut_rst_n), 32'(em));
        chk("cyc_busy", 32'(dut_busy), 32'(!ed));
        chk("cyc_done", 32'(dut_done), 32'(ed));
`ifdef RESET_SEQUENCER_CAUSE_EN
        chk("cyc_cause", 32'(dut_cause), 32'(ec));
`else
        if (ec == 3'b111) chk("cyc_cause_model", 32'(ec), 32'(3'b110));
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!dut_done && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!dut_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done timeout at %0t: done=%0b expected 1", $time, dut_done);
        end
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #1000000;
        $display("FAIL global_timeout at %0t: finished=0 expected 1", $time);
        $fatal(1, "time limit");
    end

    initial begin : stim
        int ext_left;
        int brd_left;
        int poll;

        // Power-up
        tick(3); #1;
        chk("rst_mask", 32'(dut_rst_n), 32'h0);
        chk("rst_busy", 32'(dut_busy), 32'h1);
        chk("rst_done", 32'(dut_done), 32'h0);
        tick(2); #1 areset_n = 1'b1;
        tick(2);                       // E0
        tick(15); #1;
        chk("pu_e15", 32'(dut_rst_n), 32'h0);
        tick(1); #1;
        chk("pu_e16", 32'(dut_rst_n), 32'h1);
        tick(4); #1;
        chk("pu_e20", 32'(dut_rst_n), 32'h3);
        tick(7); #1;
        chk("pu_e27", 32'(dut_rst_n), 32'h7);
        chk("pu_e27_done", 32'(dut_done), 32'h0);
        tick(1); #1;
        chk("pu_e28", 32'(dut_rst_n), 32'hf);
        chk("pu_e28_done", 32'(dut_done), 32'h1);
        chk("pu_e28_busy", 32'(dut_busy), 32'h0);

        // Software reset in RUN
        #1 sw = 1'b1;
        tick(1); #1;
        sw = 1'b0;
        chk("sw_drop", 32'(dut_rst_n), 32'h0);
        chk("sw_busy", 32'(dut_busy), 32'h1);
`ifdef RESET_SEQUENCER_CAUSE_EN
        chk("sw_cause", 32'(dut_cause), 32'h4);
`endif
        tick(15); #1;
        chk("sw_p15", 32'(dut_rst_n), 32'h0);
        tick(1); #1;
        chk("sw_p16", 32'(dut_rst_n), 32'h1);

        // External reset while two channels are out
        poll = 0;
        while (dut_rst_n != 4'b0011 && poll < 40) begin
            tick(1); #1;
            poll++;
        end
        chk("ext_reach_0011", 32'(dut_rst_n), 32'h3);
        ext = 1'b1;
        tick(2); #1;
        chk("ext_a2_still_up", 32'(dut_rst_n != '0), 32'h1);
        tick(1); #1;
        chk("ext_a3_drop", 32'(dut_rst_n), 32'h0);
`ifdef RESET_SEQUENCER_CAUSE_EN
        chk("ext_cause", 32'(dut_cause), 32'h2);
`endif
        tick(7); #1 ext = 1'b0;         // sampled high on 10 edges
        tick(17); #1;
        chk("ext_hold_a27", 32'(dut_rst_n), 32'h0);
        tick(1); #1;
        chk("ext_hold_a28", 32'(dut_rst_n), 32'h1);
        wait_done(200);

        // Asynchronous board reset in RUN
        tick(3); #2 areset_n = 1'b0;
        #1;
        chk("brd_async_mask", 32'(dut_rst_n), 32'h0);
        chk("brd_async_done", 32'(dut_done), 32'h0);
`ifdef RESET_SEQUENCER_CAUSE_EN
        chk("brd_cause", 32'(dut_cause), 32'h1);
`endif
        tick(3); #2 areset_n = 1'b1;
        wait_done(200);

        // Simultaneous ext and sw on the same sequencer edge
        tick(1); #1 ext = 1'b1;
        tick(1); #1 ext = 1'b0;
        tick(1); #1 sw = 1'b1;
        tick(1); #1 sw = 1'b0;
        chk("sim_drop", 32'(dut_rst_n), 32'h0);
`ifdef RESET_SEQUENCER_CAUSE_EN
        chk("sim_cause", 32'(dut_cause), 32'h6);
`endif
        tick(15); #1;
        chk("sim_p15", 32'(dut_rst_n), 32'h0);
        tick(1); #1;
        chk("sim_p16", 32'(dut_rst_n), 32'h1);
        wait_done(200);

        // Repeated software pulses 8 clocks apart
        for (int p = 0; p < 3; p++) begin
            #1 sw = 1'b1;
            tick(1); #1 sw = 1'b0;
            tick(7);
        end
        tick(8); #1;
        chk("rep_q15", 32'(dut_rst_n), 32'h0);
        tick(1); #1;
        chk("rep_q16", 32'(dut_rst_n), 32'h1);
        wait_done(200);

        // Randomized traffic, checked every cycle against the model
        ext_left = 0;
        brd_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tick(1); #2;
            sw = ($urandom_range(0, 79) == 0);
            if (ext_left > 0) ext_left--;
            else if ($urandom_range(0, 149) == 0) ext_left = $urandom_range(1, 12);
            ext = (ext_left > 0);
            if (brd_left > 0) brd_left--;
            else if ($urandom_range(0, 499) == 0) brd_left = $urandom_range(1, 4);
            areset_n = (brd_left == 0);
        end
        sw       = 1'b0;
        ext      = 1'b0;
        areset_n = 1'b1;
        wait_done(300);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reset_sequencer
`default_nettype wire
